// File: rtl/cart_bus_if.sv
// Cartridge bus interface: sequences CPU bus cycles onto the PRG-ROM/mapper port.
// Optional bus-conflict write emulation enabled by the macro CART_BUS_CONFLICT_EN.
`timescale 1ns/1ps
module cart_bus_if #(
  parameter int ROM_LAT = 1
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cpu_cyc_in,
  input  logic [15:0] cpu_a_in,
  input  logic        cpu_r_nw_in,
  input  logic [7:0]  cpu_d_in,
  output logic [7:0]  cpu_d_out,
  output logic        cpu_d_oe,
  output logic        prg_nce_out,
  output logic [14:0] prg_a_out,
  output logic        prg_r_nw_out,
  output logic [7:0]  prg_d_out,
  input  logic [7:0]  prg_d_in,
  output logic        overrun_out
);

  // state   | meaning
  // IDLE    | after reset, no transaction seen yet
  // SETUP   | address presented, chip enable asserted if in range
  // WAIT    | ROM access latency countdown
  // CAPTURE | sample mapper read data
  // WRITE   | single-clk write strobe (bus-conflict build only)
  // HOLD    | transaction done, read data held for the CPU
  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_CAPTURE, S_WRITE, S_HOLD
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(ROM_LAT - 1);

  state_t     r_state;
  state_t     w_next;
  logic       r_in_range;
  logic       r_rnw;
  logic [1:0] r_wait_cnt;
  logic       w_ready;
  logic       w_accept;
  logic       w_drop;
`ifdef CART_BUS_CONFLICT_EN
  logic [7:0] r_wdata;
`endif

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_HOLD);
  assign w_accept = cpu_cyc_in && w_ready;
  assign w_drop   = cpu_cyc_in && !w_ready;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HOLD: if (cpu_cyc_in) w_next = S_SETUP;
      S_SETUP: begin
        if (!r_in_range) w_next = S_HOLD;
        else if (r_rnw)  w_next = S_WAIT;
        else begin
`ifdef CART_BUS_CONFLICT_EN
          w_next = S_WAIT;
`else
          w_next = S_HOLD;
`endif
        end
      end
      S_WAIT:    if (r_wait_cnt == 2'd0) w_next = S_CAPTURE;
      S_CAPTURE: begin
`ifdef CART_BUS_CONFLICT_EN
        w_next = r_rnw ? S_HOLD : S_WRITE;
`else
        w_next = S_HOLD;
`endif
      end
      S_WRITE:   w_next = S_HOLD;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    prg_nce_out  = 1'b1;
    prg_r_nw_out = 1'b1;
    if (r_in_range && (r_state == S_SETUP || r_state == S_WAIT ||
                       r_state == S_CAPTURE || r_state == S_WRITE))
      prg_nce_out = 1'b0;
`ifdef CART_BUS_CONFLICT_EN
    if (r_state == S_WRITE) prg_r_nw_out = 1'b0;
`else
    if (r_state == S_SETUP && r_in_range && !r_rnw) prg_r_nw_out = 1'b0;
`endif
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_in_range  <= 1'b0;
      r_rnw       <= 1'b1;
      r_wait_cnt  <= 2'd0;
      prg_a_out   <= 15'd0;
      prg_d_out   <= 8'd0;
      cpu_d_out   <= 8'd0;
      cpu_d_oe    <= 1'b0;
      overrun_out <= 1'b0;
`ifdef CART_BUS_CONFLICT_EN
      r_wdata     <= 8'd0;
`endif
    end else begin
      if (w_drop) overrun_out <= 1'b1;
      if (w_accept) begin
        r_in_range <= cpu_a_in[15];
        r_rnw      <= cpu_r_nw_in;
        cpu_d_oe   <= 1'b0;
        // Out-of-range cycles leave the mapper-facing address untouched.
        if (cpu_a_in[15]) prg_a_out <= cpu_a_in[14:0];
`ifdef CART_BUS_CONFLICT_EN
        r_wdata <= cpu_d_in;
`else
        if (cpu_a_in[15] && !cpu_r_nw_in) prg_d_out <= cpu_d_in;
`endif
      end
      if (r_state == S_SETUP) r_wait_cnt <= LAT_M1;
      else if (r_state == S_WAIT && r_wait_cnt != 2'd0) r_wait_cnt <= r_wait_cnt - 2'd1;
      if (r_state == S_CAPTURE) begin
        if (r_rnw) begin
          cpu_d_out <= prg_d_in;
          cpu_d_oe  <= 1'b1;
        end
`ifdef CART_BUS_CONFLICT_EN
        // Open-drain style conflict: the ROM byte pulls written bits low.
        else prg_d_out <= r_wdata & prg_d_in;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cart_bus_if.sv
// Scoreboard bench for cart_bus_if: random and directed CPU cycles against a mapper/ROM model.
// Honours CART_BUS_CONFLICT_EN the same way the design does.
`timescale 1ns/1ps
module tb_cart_bus_if;
  localparam int ROM_LAT = 1;
`ifdef CART_BUS_CONFLICT_EN
  localparam bit CONFLICT = 1'b1;
`else
  localparam bit CONFLICT = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_cyc_in = 1'b0;
  logic [15:0] cpu_a_in = 16'h0;
  logic        cpu_r_nw_in = 1'b1;
  logic [7:0]  cpu_d_in = 8'h0;
  logic [7:0]  cpu_d_out;
  logic        cpu_d_oe;
  logic        prg_nce_out;
  logic [14:0] prg_a_out;
  logic        prg_r_nw_out;
  logic [7:0]  prg_d_out;
  logic [7:0]  prg_d_in;
  logic        overrun_out;

  cart_bus_if #(.ROM_LAT(ROM_LAT)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .cpu_cyc_in(cpu_cyc_in), .cpu_a_in(cpu_a_in),
    .cpu_r_nw_in(cpu_r_nw_in), .cpu_d_in(cpu_d_in), .cpu_d_out(cpu_d_out),
    .cpu_d_oe(cpu_d_oe), .prg_nce_out(prg_nce_out), .prg_a_out(prg_a_out),
    .prg_r_nw_out(prg_r_nw_out), .prg_d_out(prg_d_out), .prg_d_in(prg_d_in),
    .overrun_out(overrun_out)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [7:0] rom_byte(input logic [14:0] a);
    if (a == 15'h0123) return 8'h5A;
    if (a == 15'h0000) return 8'h01;
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
  endfunction

  assign prg_d_in = prg_nce_out ? 8'h00 : rom_byte(prg_a_out);

  typedef struct {
    bit         is_wr;
    logic [14:0] addr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         nce_cnt = 0;
  int         wr_cnt = 0;
  logic [7:0] page = 8'h00;
  logic [7:0] exp_page;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk_sys);
    cyc++;
  end

  // Monitor: pops the scoreboard whenever the DUT strobes a write or raises read data.
  initial begin
    logic prev_oe;
    exp_t e;
    prev_oe = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!rst_n) begin
        prev_oe = 1'b0;
        continue;
      end
      if (!prg_nce_out) nce_cnt++;
      if (!prg_r_nw_out) begin
        wr_cnt++;
        page = prg_d_out;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_write: got strobe a=%0h d=%0h required none", prg_a_out, prg_d_out);
        end else begin
          e = sb.pop_front();
          check("wr_kind", 32'(e.is_wr), 32'd1);
          check("wr_cycle", cyc, e.cyc);
          check("wr_addr", 32'(prg_a_out), 32'(e.addr));
          check("wr_data", 32'(prg_d_out), 32'(e.data));
          check("wr_nce", 32'(prg_nce_out), 32'd0);
        end
      end
      if (cpu_d_oe && !prev_oe) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_read: got oe d=%0h required none", cpu_d_out);
        end else begin
          e = sb.pop_front();
          check("rd_kind", 32'(e.is_wr), 32'd0);
          check("rd_cycle", cyc, e.cyc);
          check("rd_addr", 32'(prg_a_out), 32'(e.addr));
          check("rd_data", 32'(cpu_d_out), 32'(e.data));
        end
      end
      prev_oe = cpu_d_oe;
    end
  end

  // Issue one pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [15:0] a, input bit rnw, input logic [7:0] d, input bit accept);
    exp_t e;
    int k;
    @(negedge clk_sys);
    nce_cnt = 0;
    wr_cnt = 0;
    cpu_a_in = a; cpu_r_nw_in = rnw; cpu_d_in = d; cpu_cyc_in = 1'b1;
    k = cyc + 1;
    if (accept && a[15]) begin
      e.is_wr = !rnw;
      e.addr  = a[14:0];
      if (rnw) begin
        e.data = rom_byte(a[14:0]);
        e.cyc  = k + ROM_LAT + 2;
      end else begin
        e.data = CONFLICT ? (d & rom_byte(a[14:0])) : d;
        e.cyc  = CONFLICT ? k + ROM_LAT + 2 : k;
      end
      sb.push_back(e);
    end
    @(negedge clk_sys);
    cpu_cyc_in = 1'b0;
  endtask

  task automatic txn(input logic [15:0] a, input bit rnw, input logic [7:0] d, input int spacing);
    int exp_nce;
    bit in_r;
    in_r = a[15];
    issue(a, rnw, d, 1'b1);
    repeat (spacing - 2) @(negedge clk_sys);
    #1;
    exp_nce = !in_r ? 0 : (rnw ? ROM_LAT + 2 : (CONFLICT ? ROM_LAT + 3 : 1));
    check("nce_clks", nce_cnt, exp_nce);
    check("wr_clks", wr_cnt, (in_r && !rnw) ? 1 : 0);
    check("oe_held", 32'(cpu_d_oe), 32'(in_r && rnw));
    if (in_r && rnw) check("rd_held", 32'(cpu_d_out), 32'(rom_byte(a[14:0])));
    if (in_r && !rnw) begin
      exp_page = CONFLICT ? (d & rom_byte(a[14:0])) : d;
      check("page", 32'(page), 32'(exp_page));
    end
    check("r_nw_idle", 32'(prg_r_nw_out), 32'd1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_nce"}, 32'(prg_nce_out), 32'd1);
    check({tag, "_rnw"}, 32'(prg_r_nw_out), 32'd1);
    check({tag, "_a"}, 32'(prg_a_out), 32'd0);
    check({tag, "_pd"}, 32'(prg_d_out), 32'd0);
    check({tag, "_cd"}, 32'(cpu_d_out), 32'd0);
    check({tag, "_oe"}, 32'(cpu_d_oe), 32'd0);
    check({tag, "_ovr"}, 32'(overrun_out), 32'd0);
  endtask

  task automatic do_reset();
    check("sb_drained", sb.size(), 0);
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst");
    sb.delete();
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  initial begin
    int w0;
    #1 rst_n = 1'b0;
    #1 check_reset_outs("por");
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;

    // Directed: read returning $5A, write of $03 to $8000, out-of-range accesses.
    txn(16'h8123, 1'b1, 8'h00, ROM_LAT + 5);
    repeat (4) @(negedge clk_sys);
    #1;
    check("oe_long_hold", 32'(cpu_d_oe), 32'd1);
    check("addr_0123", 32'(prg_a_out), 32'h0123);
    txn(16'h8000, 1'b0, 8'h03, ROM_LAT + 5);
    check("page_8000", 32'(page), CONFLICT ? 32'h01 : 32'h03);
    txn(16'h6000, 1'b1, 8'h00, ROM_LAT + 5);
    txn(16'h6000, 1'b0, 8'hFF, ROM_LAT + 5);

    for (int i = 0; i < 40; i++)
      txn(16'($urandom), 1'($urandom), 8'($urandom), ROM_LAT + 5 + int'($urandom_range(0, 3)));
    check("no_overrun_yet", 32'(overrun_out), 32'd0);

    // Pulse on the first HOLD clk is accepted.
    issue(16'h8123, 1'b1, 8'h00, 1'b1);
    repeat (ROM_LAT + 1) @(negedge clk_sys);
    issue(16'h8456, 1'b1, 8'h00, 1'b1);
    repeat (ROM_LAT + 5) @(negedge clk_sys);
    #1;
    check("hold_accept_ovr", 32'(overrun_out), 32'd0);
    check("hold_accept_data", 32'(cpu_d_out), 32'(rom_byte(15'h0456)));

    // Second pulse two clks after the first is dropped.
    issue(16'h8123, 1'b1, 8'h00, 1'b1);
    issue(16'h8777, 1'b0, 8'h3C, 1'b0);
    repeat (ROM_LAT + 6) @(negedge clk_sys);
    #1;
    check("ovr_set", 32'(overrun_out), 32'd1);
    check("ovr_first_oe", 32'(cpu_d_oe), 32'd1);
    check("ovr_first_data", 32'(cpu_d_out), 32'h5A);
    check("ovr_no_write", wr_cnt, 0);
    txn(16'h8001, 1'b1, 8'h00, ROM_LAT + 5);
    check("ovr_sticky", 32'(overrun_out), 32'd1);

    do_reset();
    // Pulse on the same clk HOLD is entered counts as an overrun.
    issue(16'h8123, 1'b1, 8'h00, 1'b1);
    repeat (ROM_LAT) @(negedge clk_sys);
    issue(16'h8456, 1'b1, 8'h00, 1'b0);
    repeat (ROM_LAT + 5) @(negedge clk_sys);
    #1;
    check("hold_entry_ovr", 32'(overrun_out), 32'd1);
    check("hold_entry_data", 32'(cpu_d_out), 32'h5A);

    do_reset();
    // Reset one clk after SETUP of an in-range write (WAIT in the conflict build).
    issue(16'h8010, 1'b0, 8'hC3, 1'b1);
    @(negedge clk_sys);
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    sb.delete();
    w0 = wr_cnt;
    check("midrst_strobes", w0, CONFLICT ? 0 : 1);
    repeat (3) @(negedge clk_sys);
    #1;
    check("midrst_no_strobe", wr_cnt, w0);
    rst_n = 1'b1;
    txn(16'h8123, 1'b1, 8'h00, ROM_LAT + 5);
    check("sb_final", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cart_bus_if.md
CART_BUS_IF -- requirements
Module: cart_bus_if

Interface
REQ-001 Parameter ROM_LAT, default 1: PRG-ROM read latency in clk_sys cycles, legal range 1..3.
REQ-002 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 cpu_cyc_in  in  1  one-clk pulse marking the start of a CPU bus cycle.
REQ-005 cpu_a_in  in  16  CPU address.
REQ-006 cpu_r_nw_in  in  1  CPU read (1) / write (0).
REQ-007 cpu_d_in  in  8  CPU write data.
REQ-008 cpu_d_out  out  8  registered read data returned to the CPU.
REQ-009 cpu_d_oe  out  1  cpu_d_out valid; cartridge is driving the bus.
REQ-010 prg_nce_out  out  1  PRG chip enable to mapper, active low.
REQ-011 prg_a_out  out  15  PRG address to mapper.
REQ-012 prg_r_nw_out  out  1  PRG read/write to mapper.
REQ-013 prg_d_out  out  8  write data to mapper.
REQ-014 prg_d_in  in  8  read data from mapper (already gated by the mapper's chip enable).
REQ-015 overrun_out  out  1  sticky flag: a cpu_cyc_in pulse was dropped.

Function
REQ-016 The FSM states shall be IDLE, SETUP, WAIT, CAPTURE, WRITE, HOLD.
REQ-017 On a cpu_cyc_in pulse in IDLE or HOLD: latch cpu_a_in, cpu_r_nw_in and cpu_d_in; clear cpu_d_oe; go to SETUP.
REQ-018 Range check: a transaction is in-range iff latched address bit 15 is 1.
REQ-019 Out-of-range transaction: prg_nce_out stays 1, no mapper access, cpu_d_oe stays 0, and SETUP goes to HOLD.
REQ-020 In SETUP, for an in-range transaction: prg_a_out equals latched address bits 14:0, and prg_nce_out goes 0.
REQ-021 prg_nce_out shall stay 0 until the state leaves CAPTURE (read) or WRITE (write), then return to 1.
REQ-022 In-range read: SETUP, then WAIT for ROM_LAT clks, then CAPTURE.
REQ-023 In CAPTURE: cpu_d_out takes prg_d_in, cpu_d_oe goes 1, and the next state is HOLD.
REQ-024 cpu_d_out and cpu_d_oe shall hold their values in HOLD until the next cpu_cyc_in pulse.
REQ-025 prg_r_nw_out shall be 0 for exactly one clk per in-range write and 1 at all other times.
REQ-026 During that write clk, prg_d_out carries the write value.
REQ-027 A write never sets cpu_d_oe.
REQ-028 A cpu_cyc_in pulse in SETUP, WAIT, CAPTURE or WRITE shall be ignored, the transaction in flight shall complete unchanged, and overrun_out shall be set to 1.
REQ-029 overrun_out is cleared only by reset.
REQ-030 A cpu_cyc_in pulse on the same clk the FSM enters HOLD shall be ignored and counted as an overrun; a pulse on the first HOLD clk or later shall be accepted.
REQ-031 Minimum legal cpu_cyc_in spacing is ROM_LAT+5 clks.
REQ-032 prg_a_out and prg_d_out shall hold their last values when idle.

Reset
REQ-033 While rst_n is 0, state shall be IDLE and outputs shall be: prg_nce_out=1, prg_r_nw_out=1, prg_a_out=0, prg_d_out=0, cpu_d_out=0, cpu_d_oe=0, overrun_out=0.
REQ-034 Reset asserted mid-transaction shall abort it immediately with no further mapper write strobe.
REQ-035 The first cpu_cyc_in pulse accepted after reset release shall be the first one sampled while rst_n is 1.

Configuration
REQ-036 Macro CART_BUS_CONFLICT_EN.
REQ-037 When CART_BUS_CONFLICT_EN is defined, an in-range write shall first perform a read: SETUP, WAIT for ROM_LAT clks, CAPTURE with the data latched internally and cpu_d_oe left at 0, then WRITE.
REQ-038 With CART_BUS_CONFLICT_EN defined, WRITE drives prg_d_out = cpu_d_in AND ROM byte, with prg_r_nw_out at 0 for that one clk, then goes to HOLD.
REQ-039 When CART_BUS_CONFLICT_EN is undefined, an in-range write shall drive prg_r_nw_out=0 and prg_d_out=cpu_d_in in SETUP for one clk, then go to HOLD; WAIT, CAPTURE and WRITE are skipped.

Verification
REQ-040 Read, ROM_LAT=1: cpu_a=$8123 with the mapper returning $5A -> prg_a_out=$0123, cpu_d_out=$5A and cpu_d_oe=1 three clks after the pulse, held until the next pulse.
REQ-041 Write, macro undefined: $8000 with data $03 -> exactly one clk with prg_r_nw_out=0, prg_nce_out=0 and prg_d_out=$03; mapper page becomes 3.
REQ-042 Write, macro defined: $8000 with data $03 and ROM byte $01 -> prg_d_out=$01 during the single write clk; mapper page becomes 1.
REQ-043 Out-of-range: cpu_a=$6000, read or write -> prg_nce_out stays 1 and cpu_d_oe stays 0.
REQ-044 Overrun: second pulse two clks after the first -> first transaction completes normally and overrun_out=1 until reset.
REQ-045 Reset mid-write: rst_n driven low in WAIT -> all outputs return to reset values within the same clk, with no prg_r_nw_out=0 pulse.
